// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-4 registered stream demultiplexer.
// No logic of its own; latency and backpressure are defined by its users.
// Used by every file of the block, including the STREAM_DEMUX_STATS_EN counter build.
package stream_demux_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] port_idx_t;

    // Occupancy of a one-entry output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Saturating increment. The caller passes its all-ones value as max_val,
    // which lets one function serve any counter width up to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] max_val);
        logic [31:0] res;
        res = (cnt == max_val) ? cnt : cnt + 32'd1;
        return res;
    endfunction

endpackage

// File: rtl/stream_demux_1to4_if.sv
// Bundle of the demux input stream, per-port output streams and drop strobe.
// No latency; pure wiring.
// Backpressure: in_ready from slave to master, out_ready from master to slave.
interface stream_demux_1to4_if #(
    parameter int DATA_W = 8
);
    import stream_demux_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             in_data;
    port_idx_t                     in_sel;
    logic [NUM_PORTS-1:0]          port_en;
    logic [NUM_PORTS-1:0]          out_valid;
    logic [NUM_PORTS-1:0]          out_ready;
    logic [NUM_PORTS*DATA_W-1:0]   out_data;
    logic                          drop_pulse;

    // Environment side: drives the input stream and the downstream readies.
    modport master (
        output in_valid, in_data, in_sel, port_en, out_ready,
        input  in_ready, out_valid, out_data, drop_pulse
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel, port_en, out_ready,
        output in_ready, out_valid, out_data, drop_pulse
    );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output register slot (EMPTY/FULL) for a single demux port.
// Latency: a load at edge N is visible as out_valid/dout after edge N.
// Backpressure: holds dout stable while out_valid=1 and out_ready=0; the parent only loads when empty or draining.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout
);

    slot_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // State and data registers; reset empties the slot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: a load wins over a drain so simultaneous drain+load keeps the slot full.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                    data_d  = din;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    data_d = din;
                end else if (out_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign dout      = data_q;

endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demux: steers each accepted beat into one of four one-entry port slots; optional counters under STREAM_DEMUX_STATS_EN.
// Latency: one cycle from input accept to out_valid; drop_pulse one cycle after a dropped beat.
// Backpressure: in_ready follows the addressed port only (combinational from out_ready/port_en); beats to disabled ports are always accepted.
module stream_demux_1to4
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    stream_demux_1to4_if.slave         bus
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0] stat_fwd,
    output logic [CNT_W-1:0]           stat_drop
`endif
);

    port_idx_t                          sel;
    logic                               sel_en;
    logic                               sel_vld;
    logic                               sel_rdy;
    logic                               in_ready_w;
    logic                               accept;
    logic                               drop_d, drop_q;
    logic [NUM_PORTS-1:0]               load;
    logic [NUM_PORTS-1:0]               out_valid_w;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   dout_w;

    assign sel     = bus.in_sel;
    assign sel_en  = bus.port_en[sel];
    assign sel_vld = out_valid_w[sel];
    assign sel_rdy = bus.out_ready[sel];

    // A disabled port swallows the beat, so only an enabled, full, stalled slot blocks input.
    assign in_ready_w = ~sel_en | ~sel_vld | sel_rdy;
    assign accept     = bus.in_valid & in_ready_w;
    assign drop_d     = accept & ~sel_en;

    // One-hot load strobe towards the addressed slot, only for enabled ports.
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (accept && sel_en && (sel == port_idx_t'(k))) begin
                load[k] = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_slot
            stream_demux_slot #(
                .DATA_W   (DATA_W)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (load[g]),
                .din      (bus.in_data),
                .out_ready(bus.out_ready[g]),
                .out_valid(out_valid_w[g]),
                .dout     (dout_w[g])
            );
        end
    endgenerate

    // Drop strobe register: high for the single cycle after a discarded beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_data   = dout_w;
    assign bus.drop_pulse = drop_q;

`ifdef STREAM_DEMUX_STATS_EN
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic [NUM_PORTS-1:0][CNT_W-1:0] fwd_q;
    logic [CNT_W-1:0]                drop_cnt_q;

    // Saturating per-port forward counters and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (load[k]) begin
                    fwd_q[k] <= CNT_W'(sat_inc(32'(fwd_q[k]), CNT_MAX));
                end
            end
            if (drop_d) begin
                drop_cnt_q <= CNT_W'(sat_inc(32'(drop_cnt_q), CNT_MAX));
            end
        end
    end

    assign stat_fwd  = fwd_q;
    assign stat_drop = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed bench for stream_demux_1to4: vector table plus reset and saturation sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after an edge.
// Counter checks are present only when STREAM_DEMUX_STATS_EN is defined.
module tb_stream_demux_1to4;
    import stream_demux_pkg::*;

    localparam int DATA_W = 8;
`ifdef STREAM_DEMUX_STATS_EN
    localparam int CNT_W  = 4;
`else
    localparam int CNT_W  = 16;
`endif
    localparam int NVEC   = 16;

    logic clk;
    logic rst_n;

    stream_demux_1to4_if #(.DATA_W(DATA_W)) bus ();

`ifdef STREAM_DEMUX_STATS_EN
    logic [NUM_PORTS*CNT_W-1:0] stat_fwd;
    logic [CNT_W-1:0]           stat_drop;
`endif

    stream_demux_1to4 #(
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef STREAM_DEMUX_STATS_EN
        ,
        .stat_fwd (stat_fwd),
        .stat_drop(stat_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [7:0]  dat;
        logic [3:0]  en;
        logic [3:0]  rdy;
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
        logic        exp_drop;
    } vec_t;

    vec_t vec [NVEC];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [1:0] sel, input logic [7:0] dat,
                         input logic [3:0] en, input logic [3:0] rdy);
        bus.in_valid  = vld;
        bus.in_sel    = sel;
        bus.in_data   = dat;
        bus.port_en   = en;
        bus.out_ready = rdy;
    endtask

    initial begin
        // Full-rate steering
        vec[0]  = '{1'b1, 2'd0, 8'hA0, 4'hF, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 1'b0};
        vec[1]  = '{1'b1, 2'd1, 8'hA1, 4'hF, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 1'b0};
        vec[2]  = '{1'b1, 2'd2, 8'hA2, 4'hF, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 1'b0};
        vec[3]  = '{1'b1, 2'd3, 8'hA3, 4'hF, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 1'b0};
        vec[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0, 1'b0};
        // Backpressure isolation on port 1
        vec[5]  = '{1'b1, 2'd1, 8'hB1, 4'hF, 4'b1101, 1'b1, 4'b0010, 32'hA3A2B1A0, 1'b0};
        vec[6]  = '{1'b1, 2'd1, 8'hB2, 4'hF, 4'b1101, 1'b0, 4'b0010, 32'hA3A2B1A0, 1'b0};
        vec[7]  = '{1'b1, 2'd3, 8'hB3, 4'hF, 4'b1101, 1'b1, 4'b1010, 32'hB3A2B1A0, 1'b0};
        vec[8]  = '{1'b1, 2'd1, 8'hB2, 4'hF, 4'hF,    1'b1, 4'b0010, 32'hB3A2B2A0, 1'b0};
        vec[9]  = '{1'b0, 2'd1, 8'h00, 4'hF, 4'hF,    1'b1, 4'b0000, 32'hB3A2B2A0, 1'b0};
        // Drop to disabled port 2
        vec[10] = '{1'b1, 2'd2, 8'h55, 4'b1011, 4'hF, 1'b1, 4'b0000, 32'hB3A2B2A0, 1'b1};
        vec[11] = '{1'b0, 2'd2, 8'h00, 4'b1011, 4'hF, 1'b1, 4'b0000, 32'hB3A2B2A0, 1'b0};
        // Disabling a port does not flush its held word
        vec[12] = '{1'b1, 2'd0, 8'hC0, 4'hF,    4'h0, 1'b1, 4'b0001, 32'hB3A2B2C0, 1'b0};
        vec[13] = '{1'b1, 2'd0, 8'hC1, 4'b1110, 4'h0, 1'b1, 4'b0001, 32'hB3A2B2C0, 1'b1};
        vec[14] = '{1'b0, 2'd0, 8'h00, 4'b1110, 4'hF, 1'b1, 4'b0000, 32'hB3A2B2C0, 1'b0};
        // in_sel ignored while in_valid is low
        vec[15] = '{1'b0, 2'd3, 8'hFF, 4'hF,    4'hF, 1'b1, 4'b0000, 32'hB3A2B2C0, 1'b0};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
            @(posedge clk);
            #1;
            check($sformatf("rst_ov_%0d", c), 32'(bus.out_valid), 32'h0);
            check($sformatf("rst_od_%0d", c), bus.out_data, 32'h0);
            check($sformatf("rst_drop_%0d", c), 32'(bus.drop_pulse), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd2, 8'h00, 4'hF, 4'h0);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vec[i].vld, vec[i].sel, vec[i].dat, vec[i].en, vec[i].rdy);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vec[i].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vec[i].exp_ov));
            check($sformatf("v%0d_out_data", i), bus.out_data, vec[i].exp_od);
            check($sformatf("v%0d_drop", i), 32'(bus.drop_pulse), 32'(vec[i].exp_drop));
        end
`ifdef STREAM_DEMUX_STATS_EN
        check("stat_drop", 32'(stat_drop), 32'd2);
`endif

        // Fill all slots with downstream stalled, then reset between edges
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 2'(k), 8'hD0 + 8'(k), 4'hF, 4'h0);
            #1;
            check($sformatf("fill%0d_in_ready", k), 32'(bus.in_ready), 32'h1);
            @(posedge clk);
        end
        #1;
        check("fill_out_valid", 32'(bus.out_valid), 32'hF);
        check("fill_out_data", bus.out_data, 32'hD3D2D1D0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_out_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 8'hE0, 4'hF, 4'hF);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(bus.out_valid), 32'h1);
        check("post_rst_out_data", bus.out_data, 32'h000000E0);

`ifdef STREAM_DEMUX_STATS_EN
        // Counter saturation on port 0
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            drive(1'b1, 2'd0, 8'(b), 4'hF, 4'hF);
        end
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 4'hF, 4'hF);
        #1;
        check("stat_fwd0_sat", 32'(stat_fwd[CNT_W-1:0]), 32'd15);
        check("stat_fwd1", 32'(stat_fwd[2*CNT_W-1:CNT_W]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to4.md
# stream_demux_1to4

Registered 1-to-4 stream demultiplexer: one valid/ready input stream carries a data word plus a 2-bit destination select, and each accepted beat is steered into exactly one of four output ports. Every output port holds a one-entry register slot, so there is exactly one cycle of latency, and each port applies backpressure independently of the others. It is the distribution-side counterpart of the 4:1 select mux in the LUT-mapping benchmark set. It is used as a sequential test case for LUT and FF mapping comparisons against the Vivado flow.

## Interface
Parameters:
- DATA_W, default 8: width of the data word on the input port and on each output port.
- CNT_W, default 16: width of the statistics counters. Used only when the statistics feature is compiled in.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; release is synchronous to clk.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat will be accepted this cycle.
- in_data  input  DATA_W  payload.
- in_sel  input  2  destination port index, 0..3.
- port_en  input  4  per-port enable; a beat addressed to a disabled port is dropped.
- out_valid  output  4  per-port valid.
- out_ready  input  4  per-port ready.
- out_data  output  4*DATA_W  port k occupies bits [k*DATA_W +: DATA_W].
- drop_pulse  output  1  registered; high for one cycle after a dropped beat.

## Operation
- Slot k is empty when out_valid[k]=0.
- in_ready = ~port_en[in_sel] | ~out_valid[in_sel] | out_ready[in_sel].
  - This is a combinational path from out_ready and port_en to in_ready.
  - Downstream logic must not make out_ready depend on in_valid.
- Accept occurs when in_valid & in_ready. On accept:
  - If port_en[in_sel]=1: slot in_sel loads in_data and sets out_valid[in_sel]=1.
  - If port_en[in_sel]=0: the beat is consumed and discarded, and drop_pulse is 1 in the next cycle.
- Slot k drains when out_valid[k] & out_ready[k]. After draining, out_valid[k] clears unless the same cycle also loads slot k.
  - Simultaneous drain and load of the same slot: the new word replaces the old one and out_valid stays 1 (full throughput).
- Slots not addressed by in_sel hold their data and valid unchanged while waiting for their own out_ready.
- Data stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] must not change.
- port_en is sampled only at accept time. Disabling a port does not flush a word already in its slot; that word still drains normally.
- No ordering relation exists between different ports; ordering within one port is preserved.
- A value of in_sel while in_valid=0 is ignored.
- There is no FSM beyond the four slot-occupancy bits (state per slot: EMPTY/FULL).
  - EMPTY→FULL on load.
  - FULL→EMPTY on drain without load.
  - FULL→FULL on drain with load, or with no drain.

## Timing
- Reset values: out_valid=0, out_data=0, drop_pulse=0, all counters=0.
- in_ready is valid immediately after reset: 1 when the addressed slot is empty or the addressed port is disabled.
- Latency: a beat accepted at edge N appears on its port with out_valid=1 after edge N.
- Throughput: one beat per cycle into any single port when that port's out_ready is held at 1.
- Reset asserted mid-stream: all slots empty immediately (asynchronously); any words held are lost; there is no partial state.

## Configuration
- STREAM_DEMUX_STATS_EN defined:
  - Adds output stat_fwd, 4*CNT_W bits: per-port forwarded-beat counters, incremented on load.
  - Adds output stat_drop, CNT_W bits: dropped-beat counter.
  - All counters saturate at all-ones and do not wrap. Reset value is 0.
- STREAM_DEMUX_STATS_EN undefined:
  - These ports and their logic are absent.
  - The datapath behaviour is otherwise identical.

## Structure
- Package stream_demux_pkg holds:
  - NUM_PORTS=4 and SEL_W=2.
  - Typedef port_idx_t (SEL_W bits).
  - A saturating-increment function for CNT_W counters.
- Sub-module stream_demux_slot: the one-entry register slot.
  - Ports: load, din, out_ready → out_valid, dout.
  - Instantiated NUM_PORTS times by a generate loop.
- The top level contains the in_ready select, the drop logic and the optional counters.

## Test plan
- Reset: hold rst_n=0 with random inputs → out_valid=0000, out_data=0, drop_pulse=0; after release with in_sel=2 and port_en=1111, in_ready=1.
- Full-rate steering: port_en=1111, out_ready=1111; send data 0xA0..0xA3 with in_sel 0,1,2,3 on consecutive cycles → each word appears on its own port exactly one cycle later; in_ready is always 1.
- Backpressure isolation: out_ready[1]=0; send to port 1 twice, then to port 3 → the first word sits in port 1, in_ready=0 for the second port-1 beat, then port 3 still receives its word when the beat is re-sequenced. Raising out_ready[1] drains port 1 and accepts the pending beat the same cycle.
- Drop: port_en=1011 (port 2 disabled); send in_sel=2 with data 0x55 → accepted with in_ready=1, no out_valid change, drop_pulse=1 for exactly one cycle; with stats compiled in, stat_drop=1.
- Reset mid-operation: fill all four slots with out_ready=0000, then pulse rst_n low between clock edges → out_valid=0000 immediately; the first beat after release behaves as in the full-rate test.
- Counter saturation (STREAM_DEMUX_STATS_EN, CNT_W=4): send 20 beats to port 0 → stat_fwd[0] stops at 15.
